// File: rtl/regfile_write_scheduler_pkg.sv
// Shared register-file geometry and requester count for the writeback scheduler.
package regfile_write_scheduler_pkg;
   localparam int REG_AW = 5;
   localparam int REG_DW = 32;
   localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;
   localparam int NUM_WB_REQ = 3;
endpackage

// File: rtl/regfile_write_scheduler_rr_pick2.sv
// Combinational round-robin picker: first two eligible requesters from rr_i,
// never granting port B to the register already granted to port A.
module regfile_write_scheduler_rr_pick2
   import regfile_write_scheduler_pkg::*;
#(
   parameter int NREQ = NUM_WB_REQ,
   parameter int AW   = REG_AW,
   parameter int IW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0]    elig_i,
   input  logic [IW-1:0]      rr_i,
   input  logic [NREQ*AW-1:0] addr_i,
   output logic [NREQ-1:0]    grant_a_o,
   output logic [NREQ-1:0]    grant_b_o,
   output logic               valid_a_o,
   output logic               valid_b_o,
   output logic [IW-1:0]      rr_next_o
);
   localparam logic [IW:0] NREQ_C = (IW+1)'(NREQ);

   logic [AW-1:0] addr_s [NREQ];
   logic [NREQ-1:0] ga_s;
   logic [NREQ-1:0] gb_s;
   logic            va_s;
   logic            vb_s;
   logic [IW-1:0]   rr_nx_s;

   // Unpack the flat address bus into one entry per requester.
   always_comb begin
      for (int k = 0; k < NREQ; k++) begin
         addr_s[k] = addr_i[k*AW +: AW];
      end
   end

   // Walk requesters in rotated order and take the first two with distinct targets.
   always_comb begin
      logic [IW:0]   pos_s;
      logic [IW:0]   nxt_s;
      logic [IW-1:0] idx_s;
      logic [AW-1:0] addr_a_s;
      ga_s     = '0;
      gb_s     = '0;
      va_s     = 1'b0;
      vb_s     = 1'b0;
      rr_nx_s  = rr_i;
      addr_a_s = '0;
      pos_s    = '0;
      nxt_s    = '0;
      idx_s    = '0;
      for (int i = 0; i < NREQ; i++) begin
         pos_s = {1'b0, rr_i} + (IW+1)'(i);
         pos_s = (pos_s >= NREQ_C) ? (pos_s - NREQ_C) : pos_s;
         idx_s = pos_s[IW-1:0];
         nxt_s = ((pos_s + (IW+1)'(1)) >= NREQ_C) ? '0 : (pos_s + (IW+1)'(1));
         if (!elig_i[idx_s] || vb_s) begin
            va_s = va_s;
         end else if (!va_s) begin
            ga_s[idx_s] = 1'b1;
            va_s        = 1'b1;
            addr_a_s    = addr_s[idx_s];
            rr_nx_s     = nxt_s[IW-1:0];
         end else if (addr_s[idx_s] != addr_a_s) begin
            gb_s[idx_s] = 1'b1;
            vb_s        = 1'b1;
            rr_nx_s     = nxt_s[IW-1:0];
         end else begin
            // Same register as port A: this requester waits a cycle.
            vb_s = 1'b0;
         end
      end
   end

   assign grant_a_o = ga_s;
   assign grant_b_o = gb_s;
   assign valid_a_o = va_s;
   assign valid_b_o = vb_s;
   assign rr_next_o = rr_nx_s;
endmodule

// File: rtl/regfile_write_scheduler.sv
// Shares the register file's two write ports among NREQ writeback requesters,
// staging granted writes for one cycle and exposing a per-register busy vector.
module regfile_write_scheduler
   import regfile_write_scheduler_pkg::*;
#(
   parameter int NREQ = NUM_WB_REQ,
   parameter int AW   = REG_AW,
   parameter int DW   = REG_DW
) (
   input  logic                CLK,
   input  logic                RESET,
   input  logic [NREQ-1:0]     REQ_V,
   input  logic [NREQ*AW-1:0]  REQ_ADDR,
   input  logic [NREQ*DW-1:0]  REQ_DATA,
   output logic [NREQ-1:0]     REQ_RDY,
   output logic                MRWEA,
   output logic [AW-1:0]       WAA,
   output logic [DW-1:0]       INA,
   output logic                MRWEB,
   output logic [AW-1:0]       WAB,
   output logic [DW-1:0]       INB,
   output logic [(2**AW)-1:0]  BUSY
);
   localparam int IW   = $clog2(NREQ);
   localparam int NREG = 2**AW;

   logic [NREQ-1:0] elig_s;
   logic [NREQ-1:0] drop_s;
   logic [NREQ-1:0] grant_a_s;
   logic [NREQ-1:0] grant_b_s;
   logic            valid_a_s;
   logic            valid_b_s;
   logic [IW-1:0]   rr_next_s;

   logic [IW-1:0]   rr_q,  rr_d;
   logic            wea_q, wea_d;
   logic [AW-1:0]   waa_q, waa_d;
   logic [DW-1:0]   ina_q, ina_d;
   logic            web_q, web_d;
   logic [AW-1:0]   wab_q, wab_d;
   logic [DW-1:0]   inb_q, inb_d;
   logic [NREG-1:0] busy_s;

   // Register 0 writes are accepted and dropped; everything else competes for a port.
   always_comb begin
      elig_s = '0;
      drop_s = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (!REQ_V[k]) begin
            drop_s[k] = 1'b0;
         end else if (REQ_ADDR[k*AW +: AW] == AW'(REG_ZERO)) begin
            drop_s[k] = 1'b1;
         end else begin
            elig_s[k] = 1'b1;
         end
      end
   end

   regfile_write_scheduler_rr_pick2 #(
      .NREQ (NREQ),
      .AW   (AW),
      .IW   (IW)
   ) u_pick (
      .elig_i    (elig_s),
      .rr_i      (rr_q),
      .addr_i    (REQ_ADDR),
      .grant_a_o (grant_a_s),
      .grant_b_o (grant_b_s),
      .valid_a_o (valid_a_s),
      .valid_b_o (valid_b_s),
      .rr_next_o (rr_next_s)
   );

   assign REQ_RDY = RESET ? (drop_s | grant_a_s | grant_b_s) : '0;

   // Steer the granted requesters onto the port staging registers; idle ports hold address/data.
   always_comb begin
      wea_d = valid_a_s;
      web_d = valid_b_s;
      waa_d = waa_q;
      ina_d = ina_q;
      wab_d = wab_q;
      inb_d = inb_q;
      rr_d  = rr_next_s;
      for (int k = 0; k < NREQ; k++) begin
         if (grant_a_s[k]) begin
            waa_d = REQ_ADDR[k*AW +: AW];
            ina_d = REQ_DATA[k*DW +: DW];
         end else begin
            waa_d = waa_d;
         end
         if (grant_b_s[k]) begin
            wab_d = REQ_ADDR[k*AW +: AW];
            inb_d = REQ_DATA[k*DW +: DW];
         end else begin
            wab_d = wab_d;
         end
      end
   end

   // Staging registers and round-robin pointer; reset discards any staged write.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         rr_q  <= '0;
         wea_q <= 1'b0;
         waa_q <= '0;
         ina_q <= '0;
         web_q <= 1'b0;
         wab_q <= '0;
         inb_q <= '0;
      end else begin
         rr_q  <= rr_d;
         wea_q <= wea_d;
         waa_q <= waa_d;
         ina_q <= ina_d;
         web_q <= web_d;
         wab_q <= wab_d;
         inb_q <= inb_d;
      end
   end

   // Busy decode straight from the staged registers.
   always_comb begin
      busy_s = '0;
      if (wea_q) begin
         busy_s[waa_q] = 1'b1;
      end else begin
         busy_s = busy_s;
      end
      if (web_q) begin
         busy_s[wab_q] = 1'b1;
      end else begin
         busy_s = busy_s;
      end
      busy_s[0] = 1'b0;
   end

   assign MRWEA = wea_q;
   assign WAA   = waa_q;
   assign INA   = ina_q;
   assign MRWEB = web_q;
   assign WAB   = wab_q;
   assign INB   = inb_q;
   assign BUSY  = busy_s;
endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Bench for regfile_write_scheduler: directed vector table, corner sequences,
// then random traffic against a scan-order reference model.
module tb_regfile_write_scheduler;
   localparam int NREQ = 3;
   localparam int AW   = 5;
   localparam int DW   = 32;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  req_v;
   logic [14:0] req_addr;
   logic [95:0] req_data;
   logic [2:0]  req_rdy;
   logic        mrwea, mrweb;
   logic [4:0]  waa, wab;
   logic [31:0] ina, inb;
   logic [31:0] busy;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic [2:0]  v;
      logic [4:0]  a0, a1, a2;
      logic [2:0]  rdy;
      logic        wea;
      logic [4:0]  waa;
      logic [31:0] ina;
      logic        web;
      logic [4:0]  wab;
      logic [31:0] inb;
   } vec_t;
   vec_t tbl [8];

   logic        cv [3];
   logic [4:0]  ca [3];
   logic [31:0] cd [3];
   int          m_rr;
   logic        m_wea, m_web;
   logic [4:0]  m_waa, m_wab;
   logic [31:0] m_ina, m_inb;
   int          served [3];

   always #5 clk = ~clk;

   regfile_write_scheduler #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
      .CLK(clk), .RESET(rst_n), .REQ_V(req_v), .REQ_ADDR(req_addr), .REQ_DATA(req_data),
      .REQ_RDY(req_rdy), .MRWEA(mrwea), .WAA(waa), .INA(ina),
      .MRWEB(mrweb), .WAB(wab), .INB(inb), .BUSY(busy)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [2:0] v, input logic [4:0] a0, input logic [4:0] a1,
                        input logic [4:0] a2, input logic [31:0] d0, input logic [31:0] d1,
                        input logic [31:0] d2);
      req_v    = v;
      req_addr = {a2, a1, a0};
      req_data = {d2, d1, d0};
   endtask

   function automatic logic [31:0] busy_of(input logic wa_en, input logic [4:0] wa,
                                           input logic wb_en, input logic [4:0] wb);
      logic [31:0] b;
      b = 32'h0;
      if (wa_en) b[wa] = 1'b1;
      if (wb_en) b[wb] = 1'b1;
      b[0] = 1'b0;
      return b;
   endfunction

   initial begin
      int order [$];
      int na, nb, k;
      logic [2:0] exp_rdy;
      logic [2:0] pat [3];
      logic [31:0] eb;
      pat = '{3'b011, 3'b101, 3'b110};

      tbl[0] = '{3'b111, 5'd3, 5'd4, 5'd5, 3'b011, 1'b1, 5'd3, 32'hAA, 1'b1, 5'd4, 32'hBB};
      tbl[1] = '{3'b100, 5'd3, 5'd4, 5'd5, 3'b100, 1'b1, 5'd5, 32'hCC, 1'b0, 5'd4, 32'hBB};
      tbl[2] = '{3'b111, 5'd7, 5'd7, 5'd9, 3'b101, 1'b1, 5'd7, 32'hAA, 1'b1, 5'd9, 32'hCC};
      tbl[3] = '{3'b010, 5'd7, 5'd7, 5'd9, 3'b010, 1'b1, 5'd7, 32'hBB, 1'b0, 5'd9, 32'hCC};
      tbl[4] = '{3'b010, 5'd7, 5'd0, 5'd9, 3'b010, 1'b0, 5'd7, 32'hBB, 1'b0, 5'd9, 32'hCC};
      tbl[5] = '{3'b111, 5'd1, 5'd2, 5'd3, 3'b101, 1'b1, 5'd3, 32'hCC, 1'b1, 5'd1, 32'hAA};
      tbl[6] = '{3'b010, 5'd1, 5'd2, 5'd3, 3'b010, 1'b1, 5'd2, 32'hBB, 1'b0, 5'd1, 32'hAA};
      tbl[7] = '{3'b000, 5'd1, 5'd2, 5'd3, 3'b000, 1'b0, 5'd2, 32'hBB, 1'b0, 5'd1, 32'hAA};

      // Reset held with every requester asking
      rst_n = 1'b0;
      drive(3'b111, 5'd3, 5'd4, 5'd5, 32'hAA, 32'hBB, 32'hCC);
      repeat (2) @(negedge clk);
      #1;
      chk("reset_rdy", 64'(req_rdy), 64'(3'b000));
      chk("reset_wea", 64'(mrwea), 64'(1'b0));
      chk("reset_web", 64'(mrweb), 64'(1'b0));
      chk("reset_waa", 64'(waa), 64'(5'd0));
      chk("reset_busy", 64'(busy), 64'(32'h0));
      rst_n = 1'b1;
      #1 chk("release_rdy", 64'(req_rdy), 64'(3'b011));
      @(posedge clk); @(negedge clk);
      chk("release_wea", 64'(mrwea), 64'(1'b1));
      chk("release_waa", 64'(waa), 64'(5'd3));
      chk("release_web", 64'(mrweb), 64'(1'b1));
      chk("release_wab", 64'(wab), 64'(5'd4));
      drive(3'b100, 5'd3, 5'd4, 5'd5, 32'hAA, 32'hBB, 32'hCC);
      #1 chk("release_rr2", 64'(req_rdy), 64'(3'b100));
      @(posedge clk); @(negedge clk);

      for (int r = 0; r < 8; r++) begin
         drive(tbl[r].v, tbl[r].a0, tbl[r].a1, tbl[r].a2, 32'hAA, 32'hBB, 32'hCC);
         #1 chk("tbl_rdy", 64'(req_rdy), 64'(tbl[r].rdy));
         @(posedge clk); @(negedge clk);
         chk("tbl_wea", 64'(mrwea), 64'(tbl[r].wea));
         chk("tbl_waa", 64'(waa), 64'(tbl[r].waa));
         chk("tbl_ina", 64'(ina), 64'(tbl[r].ina));
         chk("tbl_web", 64'(mrweb), 64'(tbl[r].web));
         chk("tbl_wab", 64'(wab), 64'(tbl[r].wab));
         chk("tbl_inb", 64'(inb), 64'(tbl[r].inb));
         eb = busy_of(tbl[r].wea, tbl[r].waa, tbl[r].web, tbl[r].wab);
         chk("tbl_busy", 64'(busy), 64'(eb));
      end

      // Reset between a grant edge and its write cycle
      drive(3'b111, 5'd1, 5'd2, 5'd3, 32'hAA, 32'hBB, 32'hCC);
      #1 chk("midrst_rdy", 64'(req_rdy), 64'(3'b101));
      @(posedge clk); #1;
      chk("midrst_pre_wea", 64'(mrwea), 64'(1'b1));
      chk("midrst_pre_busy", 64'(busy), 64'(32'h0000_000A));
      rst_n = 1'b0;
      #1;
      chk("midrst_wea", 64'(mrwea), 64'(1'b0));
      chk("midrst_web", 64'(mrweb), 64'(1'b0));
      chk("midrst_busy", 64'(busy), 64'(32'h0));
      chk("midrst_rdy0", 64'(req_rdy), 64'(3'b000));
      @(negedge clk);
      rst_n = 1'b1;
      drive(3'b111, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33);

      // Fairness: all three continuously valid, pointer restarts at 0
      for (int i = 0; i < 3; i++) served[i] = 0;
      for (int c = 0; c < 6; c++) begin
         #1 chk("fair_rdy", 64'(req_rdy), 64'(pat[c % 3]));
         for (int i = 0; i < 3; i++) if (req_rdy[i] && req_v[i]) served[i]++;
         @(posedge clk); @(negedge clk);
      end
      for (int i = 0; i < 3; i++) chk("fair_served", 64'(served[i]), 64'd4);

      // Random traffic against the reference model
      rst_n = 1'b0;
      req_v = 3'b000;
      #1 rst_n = 1'b1;
      m_rr = 0; m_wea = 1'b0; m_web = 1'b0;
      m_waa = 5'd0; m_wab = 5'd0; m_ina = 32'h0; m_inb = 32'h0;
      for (int i = 0; i < 3; i++) cv[i] = 1'b0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         for (int i = 0; i < 3; i++) begin
            if (!cv[i] && ($urandom_range(0, 99) < 65)) begin
               cv[i] = 1'b1;
               ca[i] = 5'($urandom_range(0, 7));
               cd[i] = $urandom;
            end
         end
         drive({cv[2], cv[1], cv[0]}, ca[0], ca[1], ca[2], cd[0], cd[1], cd[2]);
         #1;
         order = {};
         for (int i = 0; i < NREQ; i++) order.push_back((m_rr + i) % NREQ);
         na = -1; nb = -1; exp_rdy = 3'b000;
         foreach (order[j]) begin
            k = order[j];
            if (!cv[k]) continue;
            if (ca[k] == 5'd0) begin
               exp_rdy[k] = 1'b1;
               continue;
            end
            if (na < 0) na = k;
            else if (nb < 0 && ca[k] != ca[na]) nb = k;
            else continue;
            exp_rdy[k] = 1'b1;
         end
         chk("rnd_rdy", 64'(req_rdy), 64'(exp_rdy));
         chk("rnd_wea", 64'(mrwea), 64'(m_wea));
         chk("rnd_web", 64'(mrweb), 64'(m_web));
         chk("rnd_waa", 64'(waa), 64'(m_waa));
         chk("rnd_wab", 64'(wab), 64'(m_wab));
         chk("rnd_ina", 64'(ina), 64'(m_ina));
         chk("rnd_inb", 64'(inb), 64'(m_inb));
         chk("rnd_busy", 64'(busy), 64'(busy_of(m_wea, m_waa, m_web, m_wab)));
         @(posedge clk);
         m_wea = (na >= 0);
         m_web = (nb >= 0);
         if (na >= 0) begin m_waa = ca[na]; m_ina = cd[na]; end
         if (nb >= 0) begin m_wab = ca[nb]; m_inb = cd[nb]; end
         if (nb >= 0) m_rr = (nb + 1) % NREQ;
         else if (na >= 0) m_rr = (na + 1) % NREQ;
         for (int i = 0; i < 3; i++) if (exp_rdy[i]) cv[i] = 1'b0;
         @(negedge clk);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
